bitrev_reorder_buf: RTL and testbench
=====================================

Name: bitrev_reorder_buf

Overview:
- Consumer side of the bit-reversed index stream: accepts NTT/INTT output samples arriving in bit-reversed order and re-emits them in natural order.
- Sits between the NWC butterfly datapath output and the coefficient writeback.
- Ping-pong storage of two banks, so one frame fills while the previous frame drains.
- Frame length is N = 2^(RADIX_K1*l), with l sampled at the start of each frame.

Parameters:
- DATA_W, 32, coefficient width in bits.
- RADIX_K1, 2, bits of index per stage; reorder width = RADIX_K1*l.
- LOG_N_MAX, 8, maximum reorder width; each bank holds 2^LOG_N_MAX words.
- L_W, 4, width of the l config port.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- l  in  L_W  stage count; sampled into the write bank on the first accepted sample of a frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  write bank can accept a sample.
- in_data  in  DATA_W  sample, in bit-reversed arrival order.
- out_valid  out  1  read bank holds a complete frame.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_W  sample, in natural order.
- out_last  out  1  final sample of the frame; qualified by out_valid.
- cfg_err  out  1  sticky flag: RADIX_K1*l exceeded LOG_N_MAX.

Behaviour:
- Storage and state
  - Two banks of 2^LOG_N_MAX x DATA_W flops, read asynchronously.
  - Each bank has state EMPTY / FILLING / FULL and a latched width w_b.
  - Registers: wr_sel, rd_sel (1 bit each), wr_cnt, rd_cnt (LOG_N_MAX+1 bits each).
- Width rule
  - w = RADIX_K1*l, computed at LOG_N_MAX+L_W bits.
  - If w > LOG_N_MAX: clamp w to LOG_N_MAX and set cfg_err. cfg_err clears only on rst.
  - l=0 gives w=0, N=1: a single-sample frame.
- Write side
  - in_ready = !rst && state[wr_sel] != FULL.
  - Accept on in_valid && in_ready.
  - First accept of a frame: state goes EMPTY->FILLING and w_b latches w. A change on l mid-frame is ignored.
  - Each accept writes in_data to address bitrev_w(wr_cnt), i.e. the low w bits of wr_cnt reversed, upper bits zero. wr_cnt then increments.
  - Accept with wr_cnt == N-1: bank goes FULL, wr_cnt resets to 0, wr_sel toggles.
- Read side
  - out_valid = state[rd_sel] == FULL.
  - out_data = bank[rd_sel][rd_cnt]; out_last = (rd_cnt == N_rd-1).
  - On out_valid && out_ready, rd_cnt increments.
  - On the last sample: bank goes EMPTY, rd_cnt resets to 0, rd_sel toggles.
- Latency
  - out_valid rises in the cycle after the last input of a frame is accepted.
  - Sustained throughput is 1 sample/cycle each side when both are unstalled.
- Simultaneous events
  - Write completing bank A and read completing bank B in the same cycle: both transitions apply.
  - Both banks FULL: in_ready=0 until a drain completes; in_ready rises the cycle after the last out handshake.
- Reset, including mid-frame
  - Both banks EMPTY, counters 0, wr_sel=rd_sel=0, cfg_err=0.
  - out_valid=0, out_last=0, in_ready=0 while rst is high.
  - out_data undefined-but-stable; bank contents are not cleared.
  - In-flight frames are discarded.

Optional Feature:
- Macro: BITREV_DIR_EN.
- Defined: adds input port dir (1 bit), latched per bank alongside w_b.
  - dir=0: bit-reversed->natural, as above.
  - dir=1: natural->bit-reversed. The write address is wr_cnt and the read address is bitrev_w(rd_cnt).
- Undefined: no dir port; fixed bit-reversed->natural.

Decomposition:
- Package nwc_reorder_pkg holds:
  - typedef enum bank_state_e {EMPTY, FILLING, FULL};
  - localparams RADIX_K1_DEF, LOG_N_MAX_DEF;
  - function calc_width with clamp.
- One sub-module, bitrev_var_width: combinational reversal of the low w bits of a LOG_N_MAX-bit index, w given as a runtime input. Instanced for the write address (and for the read address under BITREV_DIR_EN).

Test Plan:
- l=1 (N=4), send 10,11,12,13 with out_ready=1 -> out 10,12,11,13; out_last on 13; out_valid first high the cycle after 13 is accepted.
- l=2 (N=16), send k=0..15 as data=k -> out order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Ping-pong with out_ready=0: two l=1 frames fill, then in_ready=0. Raise out_ready -> frame1 drains, in_ready rises the cycle after its last sample, frame2 drains.
- l=0 -> every input sample emerges alone with out_last=1. l=5 -> cfg_err=1, frame length 256.
- rst pulse mid-frame (after 2 of 4 samples) -> out_valid stays 0. The next full 4-sample frame reorders correctly.
- BITREV_DIR_EN, dir=1, l=1, send 10,11,12,13 -> out 10,12,11,13. Back-to-back frames with dir=0 then dir=1 each use their own latched dir.

Source files
------------

// File: rtl/nwc_reorder_pkg.sv
// nwc_reorder_pkg: shared bank state type, default geometry and reorder-width helper
package nwc_reorder_pkg;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
   localparam int RADIX_K1_DEF = 2;
   localparam int LOG_N_MAX_DEF = 8;
   function automatic int unsigned calc_width(input int unsigned w_raw, input int unsigned w_max);
      return (w_raw > w_max) ? w_max : w_raw;
   endfunction
endpackage

// File: rtl/bitrev_var_width.sv
// bitrev_var_width: reverses the low w bits of idx, upper bits forced to zero
// Ports: idx (index), w (runtime reversal width, <= IDX_W), rev (reversed index)
module bitrev_var_width #(
   parameter int IDX_W = 8,
   parameter int WW = 4
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [WW-1:0]    w,
   output logic [IDX_W-1:0] rev
);
   always_comb begin
      rev = '0;
      for (int i = 0; i < IDX_W; i++)
         for (int j = 0; j < IDX_W; j++)
            if (i + j + 1 == int'(w)) rev[i] = idx[j];
   end
endmodule

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong buffer turning bit-reversed sample frames into natural order
// Ports: clk, rst (async, active-high); l (stage count, sampled at frame start);
//        in_valid/in_ready/in_data (bit-reversed input stream);
//        out_valid/out_ready/out_data/out_last (natural-order output stream);
//        cfg_err (sticky: RADIX_K1*l exceeded LOG_N_MAX, width clamped).
// Macro BITREV_DIR_EN: adds input dir, latched per frame; dir=1 reorders natural->bit-reversed.
module bitrev_reorder_buf
   import nwc_reorder_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RADIX_K1 = RADIX_K1_DEF,
   parameter int LOG_N_MAX = LOG_N_MAX_DEF,
   parameter int L_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [L_W-1:0]    l,
`ifdef BITREV_DIR_EN
   input  logic              dir,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              cfg_err
);
   localparam int DEPTH = 1 << LOG_N_MAX;
   localparam int WW = $clog2(LOG_N_MAX + 1);
   localparam int CW = LOG_N_MAX + 1;
   localparam int RW = LOG_N_MAX + L_W;

   logic [DATA_W-1:0] mem [2][DEPTH];
   bank_state_e st [2];
   logic [WW-1:0] wb [2];
   logic wr_sel, rd_sel;
   logic [CW-1:0] wr_cnt, rd_cnt, wr_n1, rd_n1;
   logic [RW-1:0] w_raw;
   logic [WW-1:0] w_new, w_wr, w_rd;
   logic [LOG_N_MAX-1:0] rev_wr, wr_addr, rd_addr;
   logic wr_fire, rd_fire, wr_first, wr_last, rd_last, over;

   assign w_raw = RW'(RADIX_K1) * RW'(l);
   assign over = w_raw > RW'(LOG_N_MAX);
   assign w_new = WW'(calc_width(32'(w_raw), LOG_N_MAX));
   // A bank still EMPTY has no latched width yet, so the first sample uses the live l
   assign wr_first = st[wr_sel] == EMPTY;
   assign w_wr = wr_first ? w_new : wb[wr_sel];
   assign w_rd = wb[rd_sel];
   assign wr_n1 = (CW'(1) << w_wr) - CW'(1);
   assign rd_n1 = (CW'(1) << w_rd) - CW'(1);
   assign in_ready = !rst && st[wr_sel] != FULL;
   assign wr_fire = in_valid && in_ready;
   assign wr_last = wr_cnt == wr_n1;
   assign out_valid = st[rd_sel] == FULL;
   assign rd_last = rd_cnt == rd_n1;
   assign out_last = out_valid && rd_last;
   assign rd_fire = out_valid && out_ready;

   bitrev_var_width #(.IDX_W(LOG_N_MAX), .WW(WW)) u_rev_wr (
      .idx(wr_cnt[LOG_N_MAX-1:0]),
      .w  (w_wr),
      .rev(rev_wr)
   );

`ifdef BITREV_DIR_EN
   logic db [2];
   logic d_wr;
   logic [LOG_N_MAX-1:0] rev_rd;
   assign d_wr = wr_first ? dir : db[wr_sel];
   bitrev_var_width #(.IDX_W(LOG_N_MAX), .WW(WW)) u_rev_rd (
      .idx(rd_cnt[LOG_N_MAX-1:0]),
      .w  (w_rd),
      .rev(rev_rd)
   );
   assign wr_addr = d_wr ? wr_cnt[LOG_N_MAX-1:0] : rev_wr;
   assign rd_addr = db[rd_sel] ? rev_rd : rd_cnt[LOG_N_MAX-1:0];
`else
   assign wr_addr = rev_wr;
   assign rd_addr = rd_cnt[LOG_N_MAX-1:0];
`endif

   assign out_data = mem[rd_sel][rd_addr];

   always_ff @(posedge clk)
      if (wr_fire) mem[wr_sel][wr_addr] <= in_data;

   // Write and read always target different banks (read bank is FULL, write bank is not),
   // so both transitions can land in the same cycle without conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= '{EMPTY, EMPTY};
         wb <= '{default: '0};
`ifdef BITREV_DIR_EN
         db <= '{default: 1'b0};
`endif
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (wr_fire) begin
            if (wr_first) begin
               st[wr_sel] <= FILLING;
               wb[wr_sel] <= w_new;
`ifdef BITREV_DIR_EN
               db[wr_sel] <= dir;
`endif
               if (over) cfg_err <= 1'b1;
            end
            wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
            if (wr_last) begin
               st[wr_sel] <= FULL;
               wr_sel <= !wr_sel;
            end
         end
         if (rd_fire) begin
            rd_cnt <= rd_last ? '0 : rd_cnt + CW'(1);
            if (rd_last) begin
               st[rd_sel] <= EMPTY;
               rd_sel <= !rd_sel;
            end
         end
      end
   end
endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// tb_bitrev_reorder_buf: randomized self-checking bench with a queue-based reorder model
module tb_bitrev_reorder_buf;
   localparam int DATA_W = 32;
   logic clk = 0, rst = 0;
   logic [3:0] l = 0;
   logic in_valid = 0, out_ready = 0;
   logic [DATA_W-1:0] in_data = 0;
`ifdef BITREV_DIR_EN
   logic dir = 0;
`endif
   logic in_ready, out_valid, out_last, cfg_err;
   logic [DATA_W-1:0] out_data;
   int passed = 0, total = 0;
   logic [DATA_W:0] got_q[$], exp_q[$];
   bit busy = 0;

   bitrev_reorder_buf dut (
      .clk(clk), .rst(rst), .l(l),
`ifdef BITREV_DIR_EN
      .dir(dir),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});

   function automatic int rev(input int j, input int w);
      int r = 0;
      for (int b = 0; b < w; b++)
         if ((j >> b) & 1) r += 1 << (w - 1 - b);
      return r;
   endfunction

   // Natural output slot j carries the sample that arrived at position rev(j)
   task automatic add_frame(input int w, input logic [DATA_W-1:0] x[$]);
      for (int j = 0; j < (1 << w); j++)
         exp_q.push_back({j == (1 << w) - 1, x[rev(j, w)]});
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      int t = 0;
      in_valid = 1;
      in_data = d;
      @(negedge clk);
      while (!in_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         total++;
         $display("FAIL push_timeout in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic wait_outs(input int n);
      int t = 0;
      while (got_q.size() < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1 rst = 1;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b expected 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b expected 0", out_valid); else passed++;
      total++; if (out_last !== 1'b0) $display("FAIL rst_out_last got %b expected 0", out_last); else passed++;
      total++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b expected 0", cfg_err); else passed++;
      rst = 0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b expected 1", in_ready); else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_n4;
      int e[4] = '{10, 12, 11, 13};
      got_q.delete();
      l = 1;
      out_ready = 1;
      push(10); push(11); push(12);
      total++; if (out_valid !== 1'b0) $display("FAIL n4_early_valid got %b expected 0", out_valid); else passed++;
      push(13);
      total++; if (out_valid !== 1'b1) $display("FAIL n4_latency got %b expected 1", out_valid); else passed++;
      wait_outs(4);
      total++; if (got_q.size() != 4) $display("FAIL n4_count got %0d expected 4", got_q.size()); else passed++;
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== {i == 3, DATA_W'(e[i])}) $display("FAIL n4[%0d] got %h expected %h", i, got_q[i], {i == 3, DATA_W'(e[i])});
         else passed++;
      end
   endtask

   task automatic test_n16;
      int e[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      got_q.delete();
      l = 2;
      out_ready = 1;
      for (int k = 0; k < 16; k++) push(DATA_W'(k));
      wait_outs(16);
      total++; if (got_q.size() != 16) $display("FAIL n16_count got %0d expected 16", got_q.size()); else passed++;
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== {i == 15, DATA_W'(e[i])}) $display("FAIL n16[%0d] got %h expected %h", i, got_q[i], {i == 15, DATA_W'(e[i])});
         else passed++;
      end
   endtask

   task automatic test_pingpong;
      logic [DATA_W-1:0] x[$];
      got_q.delete();
      exp_q.delete();
      l = 1;
      out_ready = 0;
      for (int f = 0; f < 2; f++) begin
         x.delete();
         for (int k = 0; k < 4; k++) x.push_back($urandom);
         add_frame(2, x);
         for (int k = 0; k < 4; k++) push(x[k]);
      end
      total++; if (in_ready !== 1'b0) $display("FAIL pp_full_in_ready got %b expected 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL pp_full_out_valid got %b expected 1", out_valid); else passed++;
      repeat (3) @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL pp_stall_in_ready got %b expected 0", in_ready); else passed++;
      @(posedge clk);
      #1 out_ready = 1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         total++;
         if (in_ready !== (c == 5)) $display("FAIL pp_in_ready[%0d] got %b expected %b", c, in_ready, c == 5);
         else passed++;
      end
      wait_outs(8);
      total++; if (got_q.size() != 8) $display("FAIL pp_count got %0d expected 8", got_q.size()); else passed++;
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL pp[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
   endtask

   task automatic test_l0;
      logic [DATA_W-1:0] d;
      got_q.delete();
      exp_q.delete();
      l = 0;
      out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         d = $urandom;
         exp_q.push_back({1'b1, d});
         push(d);
         total++;
         if (out_valid !== 1'b1 || out_last !== 1'b1) $display("FAIL l0_single[%0d] got valid=%b last=%b expected 1 1", k, out_valid, out_last);
         else passed++;
      end
      wait_outs(3);
      total++; if (got_q.size() != 3) $display("FAIL l0_count got %0d expected 3", got_q.size()); else passed++;
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL l0[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
   endtask

   task automatic test_cfg_err;
      logic [DATA_W-1:0] x[$];
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < 256; k++) x.push_back($urandom);
      add_frame(8, x);
      l = 5;
      out_ready = 1;
      push(x[0]);
      total++; if (cfg_err !== 1'b1) $display("FAIL cfg_err got %b expected 1", cfg_err); else passed++;
      for (int k = 1; k < 255; k++) push(x[k]);
      total++; if (out_valid !== 1'b0) $display("FAIL cfg_len_early got %b expected 0", out_valid); else passed++;
      push(x[255]);
      total++; if (out_valid !== 1'b1) $display("FAIL cfg_len_done got %b expected 1", out_valid); else passed++;
      wait_outs(256);
      total++; if (got_q.size() != 256) $display("FAIL cfg_count got %0d expected 256", got_q.size()); else passed++;
      for (int i = 0; i < 256 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL cfg[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      total++; if (cfg_err !== 1'b1) $display("FAIL cfg_sticky got %b expected 1", cfg_err); else passed++;
   endtask

   task automatic test_rst_mid;
      logic [DATA_W-1:0] x[$];
      got_q.delete();
      exp_q.delete();
      l = 1;
      out_ready = 1;
      push($urandom);
      push($urandom);
      @(negedge clk);
      rst = 1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %b expected 0", in_ready); else passed++;
      total++; if (cfg_err !== 1'b0) $display("FAIL rst_mid_cfg_err got %b expected 0", cfg_err); else passed++;
      @(negedge clk);
      rst = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) $display("FAIL rst_mid_valid[%0d] got %b expected 0", c, out_valid);
         else passed++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) x.push_back($urandom);
      add_frame(2, x);
      for (int k = 0; k < 4; k++) push(x[k]);
      wait_outs(4);
      total++; if (got_q.size() != 4) $display("FAIL rst_mid_count got %0d expected 4", got_q.size()); else passed++;
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rst_mid[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      logic [DATA_W-1:0] x[$];
      int lv;
      got_q.delete();
      exp_q.delete();
      busy = 1;
      fork
         begin
            for (int f = 0; f < 8; f++) begin
               lv = $urandom_range(0, 3);
               x.delete();
               for (int k = 0; k < (1 << (2 * lv)); k++) x.push_back($urandom);
               add_frame(2 * lv, x);
               l = 4'(lv);
               for (int k = 0; k < x.size(); k++) begin
                  push(x[k]);
                  if (k == 0) l = 4'($urandom_range(0, 3));
                  if ($urandom_range(0, 3) == 0) begin
                     @(posedge clk);
                     #1;
                  end
               end
            end
            busy = 0;
         end
         begin
            while (busy) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1;
         end
      join
      wait_outs(exp_q.size());
      total++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL b2b[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
   endtask

`ifdef BITREV_DIR_EN
   task automatic test_dir;
      int e[4] = '{10, 12, 11, 13};
      logic [DATA_W-1:0] x[$];
      got_q.delete();
      exp_q.delete();
      l = 1;
      dir = 1;
      out_ready = 1;
      push(10); push(11); push(12); push(13);
      wait_outs(4);
      for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, DATA_W'(e[i])});
      out_ready = 0;
      for (int f = 0; f < 2; f++) begin
         x.delete();
         for (int k = 0; k < 4; k++) x.push_back($urandom);
         add_frame(2, x);
         dir = (f == 1);
         for (int k = 0; k < 4; k++) begin
            push(x[k]);
            dir = (f == 0);
         end
      end
      out_ready = 1;
      wait_outs(12);
      total++; if (got_q.size() != 12) $display("FAIL dir_count got %0d expected 12", got_q.size()); else passed++;
      for (int i = 0; i < 12 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) $display("FAIL dir[%0d] got %h expected %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
      dir = 0;
   endtask
`endif

   initial begin
      test_reset;
      test_n4;
      test_n16;
      test_pingpong;
      test_l0;
      test_cfg_err;
      test_rst_mid;
      test_back_to_back;
`ifdef BITREV_DIR_EN
      test_dir;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
